// File: rtl/skylark_mem_pkg.sv
// Types and constants shared by the unified-memory arbiter and its helpers.
package skylark_mem_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} resp_owner_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating 4-bit count of consecutive denied fetch cycles; sat flags MAX_WAIT reached.
// Registered count, combinational sat; clr wins over inc.
module mem_arb_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= 4'd0;
        end else if (inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign sat = (r_cnt == MAX_CNT);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between fetch (I) and data (D); grants are combinational, read data returns next cycle.
// D has priority with fetch aging by default; MEM_ARB_ROUND_ROBIN_EN alternates conflict winners instead.
module mem_arbiter
    import skylark_mem_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int AHI = ADDR_W + BYTE_OFF_W - 1;

    logic        w_run;
    logic        w_conflict;
    logic        w_i_pref;
    logic        w_unused;
    resp_owner_t r_resp_owner;

    assign w_run      = ~reset;
    assign w_conflict = i_req & d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when D won the most recent conflict; reset value lets D take the first one.
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_conflict) begin
            r_last_d <= ~r_last_d;
        end
    end

    assign w_i_pref = r_last_d;
`else
    logic w_sat;

    mem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (i_req & ~i_gnt),
        .clr   (i_gnt | ~i_req),
        .sat   (w_sat)
    );

    assign w_i_pref = w_sat;
`endif

    assign i_gnt = w_run & i_req & (~d_req | w_i_pref);
    assign d_gnt = w_run & d_req & ~(i_req & w_i_pref);

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_wdata = d_gnt ? d_wdata : 32'd0;

    always_comb begin
        mem_addr = '0;
        if (i_gnt) begin
            mem_addr = i_addr[AHI:BYTE_OFF_W];
        end else if (d_gnt) begin
            mem_addr = d_addr[AHI:BYTE_OFF_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_owner <= OWN_NONE;
        end else if (i_gnt) begin
            r_resp_owner <= OWN_I;
        end else if (d_gnt && !d_we) begin
            r_resp_owner <= OWN_D;
        end else begin
            r_resp_owner <= OWN_NONE;
        end
    end

    // Gating with reset drops a response owed to a read granted just before reset.
    assign i_rvalid = w_run & (r_resp_owner == OWN_I);
    assign d_rvalid = w_run & (r_resp_owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;

    assign w_unused = ^{i_addr[31:AHI+1], i_addr[BYTE_OFF_W-1:0],
                        d_addr[31:AHI+1], d_addr[BYTE_OFF_W-1:0]};
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory macro model and a rule-level reference model.
module tb_mem_arbiter;
    localparam int ADDR_W   = 6;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 64;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:DEPTH-1];

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous memory macro, preloaded with each word's index.
    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = k;
        mem_rdata = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-cycle arbitration from the request rules, plus pending-response tracking.
    initial begin : model
        int          denied;
        bit          last_d;
        int          pend;
        logic [31:0] pend_data;
        logic [31:0] exp_mem [0:DEPTH-1];
        bit          iw;
        bit          dw;
        int          widx;
        denied = 0;
        last_d = 1'b0;
        pend   = 0;
        pend_data = 32'd0;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = k;
        forever begin
            @(negedge clk);
            if (reset) begin
                iw = 1'b0;
                dw = 1'b0;
            end else if (RR) begin
                iw = i_req && (!d_req || last_d);
                dw = d_req && !iw;
            end else begin
                iw = i_req && (!d_req || (denied >= MAX_WAIT));
                dw = d_req && !iw;
            end
            widx = iw ? int'((i_addr >> 2) % DEPTH) : (dw ? int'((d_addr >> 2) % DEPTH) : 0);

            check("i_gnt", {31'd0, i_gnt}, {31'd0, iw});
            check("d_gnt", {31'd0, d_gnt}, {31'd0, dw});
            check("mem_en", {31'd0, mem_en}, {31'd0, iw || dw});
            check("mem_we", {31'd0, mem_we}, {31'd0, dw && d_we});
            check("mem_addr", 32'(mem_addr), widx);
            check("mem_wdata", mem_wdata, dw ? d_wdata : 32'd0);
            check("i_rvalid", {31'd0, i_rvalid}, {31'd0, !reset && pend == 1});
            check("i_rdata", i_rdata, (!reset && pend == 1) ? pend_data : 32'd0);
            check("d_rvalid", {31'd0, d_rvalid}, {31'd0, !reset && pend == 2});
            check("d_rdata", d_rdata, (!reset && pend == 2) ? pend_data : 32'd0);

            if (reset) begin
                denied = 0;
                last_d = 1'b0;
                pend   = 0;
            end else begin
                if (i_req && d_req) last_d = dw;
                if (i_req && !iw) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
                else              denied = 0;
                pend = 0;
                if (iw) begin
                    pend = 1;
                    pend_data = exp_mem[widx];
                end else if (dw && !d_we) begin
                    pend = 2;
                    pend_data = exp_mem[widx];
                end else if (dw && d_we) begin
                    exp_mem[widx] = d_wdata;
                end
            end
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [9:0] pat_i;
        pat_i = RR ? 10'b10_1010_1010 : 10'b10_0001_0000;

        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_no_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
            check("rst_mem_en", {31'd0, mem_en}, 32'd0);
            adv();
        end

        // Fetch-only stream.
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(k < 3, 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (k < 3) check("ifetch_gnt", {31'd0, i_gnt}, 32'd1);
            if (k > 0) begin
                check("ifetch_rvalid", {31'd0, i_rvalid}, 32'd1);
                check("ifetch_rdata", i_rdata, 32'(k - 1));
                check("ifetch_d_quiet", {d_gnt, d_rvalid} == 2'b00 ? 32'd0 : 32'd1, 32'd0);
            end
            adv();
        end

        // Data write then read-back.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        check("dwr_mem_we", {31'd0, mem_we}, 32'd1);
        check("dwr_mem_addr", 32'(mem_addr), 32'd4);
        adv();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("dwr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        adv();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("drd_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("drd_rdata", d_rdata, 32'hDEADBEEF);
        adv();

        // Address wrap and ignored byte offset.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        check("wrap_addr", 32'(mem_addr), 32'd0);
        adv();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);
        @(negedge clk);
        check("boff_addr", 32'(mem_addr), 32'd4);
        check("wrap_rdata", d_rdata, 32'd0);
        adv();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("boff_rdata", d_rdata, 32'hDEADBEEF);
        adv();

        // Continuous conflict: fetch word 8, data word 9.
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0);
            else        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (k < 10) check("conf_i_gnt", {31'd0, i_gnt}, {31'd0, pat_i[k]});
            if (k > 0) begin
                if (pat_i[k-1]) begin
                    check("conf_i_tag", {i_rvalid, d_rvalid} == 2'b10 ? i_rdata : 32'hFFFF_FFFF, 32'd8);
                end else begin
                    check("conf_d_tag", {i_rvalid, d_rvalid} == 2'b01 ? d_rdata : 32'hFFFF_FFFF, 32'd9);
                end
            end
            adv();
        end

        // Reset right after a fetch grant.
        drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("pre_rst_gnt", {31'd0, i_gnt}, 32'd1);
        adv();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_rvalid_supp", {31'd0, i_rvalid}, 32'd0);
        check("rst_rdata_zero", i_rdata, 32'd0);
        adv();
        @(negedge clk);
        check("rst2_rvalid", {31'd0, i_rvalid}, 32'd0);
        adv();
        reset = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        check("post_rst_conf", {30'd0, i_gnt, d_gnt}, 32'd1);
        adv();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_rdata", d_rvalid ? d_rdata : 32'hFFFF_FFFF, 32'd1);
        adv();
        adv();
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
